// File: rtl/bids_ctrl_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bids_ctrl_sequencer_pkg
// Description : Shared definitions for the bids22 control sequencer. Holds
//               the engine opcode encoding, the sequencer-only START_OP and
//               SEQ_TIMEOUT codes, and the sequencer state enumeration.
// Revision    : 1.0 - initial release
// ============================================================================
package bids_ctrl_sequencer_pkg;

    // Engine opcode encoding. NO_OP is what the engine sees while idle.
    typedef enum logic [3:0] {
        NO_OP  = 4'h0,
        LOADX  = 4'h1,
        LOADY  = 4'h2,
        LOCK   = 4'h3,
        UNLOCK = 4'h4,
        CLEAR  = 4'h5
    } bids_op_t;

    // Host-only opcode: run a timed bidding round. Never forwarded on C_op.
    localparam logic [3:0] START_OP    = 4'hF;

    // err_code value reported when the engine never becomes ready.
    localparam logic [3:0] SEQ_TIMEOUT = 4'h8;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_ISSUE      = 3'd1,
        S_WAIT_READY = 3'd2,
        S_START      = 3'd3,
        S_WAIT_OVER  = 3'd4,
        S_HALT       = 3'd5
    } seq_state_t;

    function automatic logic is_start_op(input logic [3:0] op);
        return op == START_OP;
    endfunction

endpackage : bids_ctrl_sequencer_pkg
`default_nettype wire

// File: rtl/bids_ctrl_sequencer_fifo.sv
`default_nettype none
// ============================================================================
// Module      : bids_cmd_fifo
// Description : Synchronous host command FIFO. The head entry is presented
//               from the register array so the sequencer can decode it in
//               the same cycle it pops. Flush has priority over push/pop.
// Ports       : clk_i/reset_i   clock and synchronous active-high reset
//               push_i/pop_i    write / read strobes (ignored when full/empty)
//               flush_i         discard all contents
//               din_i/dout_o    entry in / head entry out
//               full_o/empty_o  occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module bids_cmd_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] din_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] dout_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;

    logic w_do_push;
    logic w_do_pop;

    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign w_do_push = push_i && !full_o;
    assign w_do_pop  = pop_i && !empty_o;
    assign dout_o    = mem_q[rd_ptr_q];

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk_i) begin
        if (reset_i || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (w_do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: occupancy is tracked by count_q alone.
    always_ff @(posedge clk_i) begin
        if (w_do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule : bids_cmd_fifo
`default_nettype wire

// File: rtl/bids_ctrl_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : bids_ctrl_sequencer
// Description : Host-side command sequencer in front of the bids22 bidding
//               engine. Queues host commands, issues configuration opcodes
//               one per slot, runs timed bidding rounds and records their
//               results, and halts/flushes on any engine error.
// Ports       : clk_i, reset_i            clock, synchronous active-high reset
//               cmd_valid_i/cmd_ready_o   host command handshake
//               cmd_op_i/cmd_data_i       opcode (or START_OP) and payload
//               clr_err_i                 leave HALT
//               C_op_o/C_data_o/C_start_o engine control port
//               eng_*_i                   engine status / round result
//               busy_o, halted_o          sequencer status
//               err_code_o                last captured error
//               last_max_bid_o            winning bid of last round
//               round_count_o             completed rounds (wrapping)
// Revision    : 1.0 - initial release
// ============================================================================
module bids_ctrl_sequencer
    import bids_ctrl_sequencer_pkg::*;
#(
    parameter int DATAWIDTH    = 32,
    parameter int FIFODEPTH    = 4,
    parameter int READYTIMEOUT = 255
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic [3:0]           cmd_op_i,
    input  logic [DATAWIDTH-1:0] cmd_data_i,
    input  logic                 clr_err_i,
    output logic [3:0]           C_op_o,
    output logic [DATAWIDTH-1:0] C_data_o,
    output logic                 C_start_o,
    input  logic                 eng_ready_i,
    input  logic [2:0]           eng_err_i,
    input  logic                 eng_roundOver_i,
    input  logic [DATAWIDTH-1:0] eng_maxBid_i,
    output logic                 busy_o,
    output logic                 halted_o,
    output logic [3:0]           err_code_o,
    output logic [DATAWIDTH-1:0] last_max_bid_o,
    output logic [15:0]          round_count_o
);

    localparam int TOW = $clog2(READYTIMEOUT + 1);
    localparam int CW  = DATAWIDTH + 4;

    seq_state_t           state_q, state_d;
    logic [3:0]           op_q, op_d;
    logic [DATAWIDTH-1:0] data_q, data_d;
    logic [DATAWIDTH-1:0] len_q, len_d;
    logic [TOW-1:0]       to_q, to_d;
    logic [3:0]           err_q, err_d;
    logic [DATAWIDTH-1:0] max_q, max_d;
    logic [15:0]          rc_q, rc_d;

    logic                 w_push;
    logic                 w_pop;
    logic                 w_flush;
    logic                 w_full;
    logic                 w_empty;
    logic [CW-1:0]        w_head;
    logic [3:0]           w_head_op;
    logic [DATAWIDTH-1:0] w_head_data;

    // ------------------------------------------------------------------
    // Command queue
    // ------------------------------------------------------------------
    assign cmd_ready_o = !w_full && (state_q != S_HALT);
    assign w_push      = cmd_valid_i && cmd_ready_o;
    assign w_pop       = (state_q == S_IDLE) && !w_empty;
    // Flushing on the edge into HALT also drops a push made in that cycle.
    assign w_flush     = (state_d == S_HALT);
    assign w_head_op   = w_head[CW-1 -: 4];
    assign w_head_data = w_head[DATAWIDTH-1:0];

    bids_cmd_fifo #(
        .WIDTH (CW),
        .DEPTH (FIFODEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .flush_i (w_flush),
        .din_i   ({cmd_op_i, cmd_data_i}),
        .full_o  (w_full),
        .empty_o (w_empty),
        .dout_o  (w_head)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        data_d  = data_q;
        len_d   = len_q;
        to_d    = to_q;
        err_d   = err_q;
        max_d   = max_q;
        rc_d    = rc_q;

        case (state_q)
            S_IDLE: begin
                if (!w_empty) begin
                    if (is_start_op(w_head_op)) begin
                        state_d = S_WAIT_READY;
                        // A zero-length round still runs for one cycle.
                        len_d   = (w_head_data == '0) ? DATAWIDTH'(1) : w_head_data;
                        to_d    = '0;
                    end else begin
                        state_d = S_ISSUE;
                        op_d    = w_head_op;
                        data_d  = w_head_data;
                    end
                end
            end

            S_ISSUE: begin
                // The engine reports errors combinationally on C_op, so
                // this is the only cycle the opcode's error is visible.
                if (eng_err_i != 3'd0) begin
                    err_d   = {1'b0, eng_err_i};
                    state_d = S_HALT;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_WAIT_READY: begin
                if (eng_ready_i) begin
                    state_d = S_START;
                end else if (to_q == TOW'(READYTIMEOUT - 1)) begin
                    err_d   = SEQ_TIMEOUT;
                    state_d = S_HALT;
                end else begin
                    to_d = to_q + TOW'(1);
                end
            end

            S_START: begin
                if (eng_err_i != 3'd0) begin
                    err_d   = {1'b0, eng_err_i};
                    state_d = S_HALT;
                end else if (len_q <= DATAWIDTH'(1)) begin
                    state_d = S_WAIT_OVER;
                end else begin
                    len_d = len_q - DATAWIDTH'(1);
                end
            end

            S_WAIT_OVER: begin
                if (eng_roundOver_i) begin
                    max_d   = eng_maxBid_i;
                    rc_d    = rc_q + 16'd1;
                    state_d = S_IDLE;
                end
            end

            S_HALT: begin
                if (clr_err_i) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            op_q    <= NO_OP;
            data_q  <= '0;
            len_q   <= '0;
            to_q    <= '0;
            err_q   <= '0;
            max_q   <= '0;
            rc_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            data_q  <= data_d;
            len_q   <= len_d;
            to_q    <= to_d;
            err_q   <= err_d;
            max_q   <= max_d;
            rc_q    <= rc_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign C_op_o         = (state_q == S_ISSUE) ? op_q : NO_OP;
    assign C_data_o       = (state_q == S_ISSUE) ? data_q : '0;
    assign C_start_o      = (state_q == S_START);
    assign busy_o         = (state_q != S_IDLE) || !w_empty;
    assign halted_o       = (state_q == S_HALT);
    assign err_code_o     = err_q;
    assign last_max_bid_o = max_q;
    assign round_count_o  = rc_q;

endmodule : bids_ctrl_sequencer
`default_nettype wire

// File: doc/bids_ctrl_sequencer.md
# bids_ctrl_sequencer

Host-side command sequencer that sits directly upstream of the bids22 bidding engine and drives its control port (C_op, C_data, C_start). Buffers host commands in a small FIFO and issues configuration opcodes one per slot. Runs timed bidding rounds (holds C_start for a programmed cycle count) and collects each round's result. Halts and flushes the queue on any engine error until the host clears it.

## Interface
- DATAWIDTH, 32, width of command data, C_data and maxBid
- FIFODEPTH, 4, host command FIFO depth (power of 2, ≥2)
- READYTIMEOUT, 255, max cycles to wait for engine ready before a START
- clk  in  1  sole clock; everything is rising-edge
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  host command valid
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  4  engine opcode (bids22defs encoding) or START_OP (4'hF)
- cmd_data  in  DATAWIDTH  opcode payload; for START_OP, round length in cycles
- clr_err  in  1  pulse: leave HALT
- C_op  out  4  opcode to engine
- C_data  out  DATAWIDTH  data to engine
- C_start  out  1  round-active to engine
- eng_ready  in  1  engine ready (locked)
- eng_err  in  3  engine error code, 0 = none
- eng_roundOver  in  1  engine round finished
- eng_maxBid  in  DATAWIDTH  winning bid, valid with eng_roundOver
- busy  out  1  state ≠ IDLE or FIFO non-empty
- halted  out  1  state == HALT
- err_code  out  4  captured error: engine code, or SEQ_TIMEOUT (4'h8)
- last_max_bid  out  DATAWIDTH  maxBid of most recent completed round
- round_count  out  16  completed rounds, wraps at 2^16

## Operation
- Reset: state IDLE, FIFO empty, C_op=NO_OP(0), C_data=0, C_start=0, cmd_ready=1, busy=0, halted=0, err_code=0, last_max_bid=0, round_count=0.
- Push: when cmd_valid && cmd_ready. cmd_ready = !full && state≠HALT. No bypass: a push while full is impossible by construction.
- States: IDLE, ISSUE, WAIT_READY, START, WAIT_OVER, HALT.
- IDLE: if FIFO non-empty, pop. Non-START_OP goes to ISSUE. START_OP goes to WAIT_READY, latching len = max(cmd_data, 1) and clearing the timeout counter.
- ISSUE (exactly 1 cycle): C_op/C_data = popped command. Engine err is combinational on C_op, so sample eng_err in this cycle. Nonzero → err_code = {1'b0, eng_err}, go HALT. Otherwise go IDLE.
- WAIT_READY: eng_ready=1 → START. Counter reaching READYTIMEOUT → err_code=SEQ_TIMEOUT, go HALT.
- START: C_start=1 for exactly len consecutive cycles (down-counter), then WAIT_OVER. eng_err≠0 in any START cycle → capture, drop C_start, go HALT.
- WAIT_OVER: C_start=0. On eng_roundOver: last_max_bid ← eng_maxBid, round_count+1, go IDLE. No timeout.
- HALT: FIFO is flushed on entry. Host pushes are refused. C_op=NO_OP, C_start=0. clr_err → IDLE; err_code holds until the next error.
- C_op=NO_OP and C_data=0 in every state except ISSUE.
- Width rules: len counter is DATAWIDTH bits. round_count wraps to 0 with no flag. Timeout counter is $clog2(READYTIMEOUT+1) bits.

## Timing
- Command accepted in cycle k (FIFO empty, IDLE): popped at k+1, driven on C_op at k+2. Back-to-back commands issue every 2 cycles (IDLE/ISSUE alternation).
- Pop and push in the same cycle are both honoured. Count is unchanged, and cmd_ready stays as computed from pre-edge count.
- START_OP with len=N: C_start high for cycles s..s+N−1, where s is the cycle after eng_ready is seen high.
- Reset asserted mid-round: next edge returns all outputs to reset values, dropping C_start immediately.
- clr_err and a new error in the same cycle: HALT→IDLE wins, because errors are only sampled in ISSUE/START.

## Structure
- Add to bids22defs: START_OP=4'hF, SEQ_TIMEOUT=4'h8, and the seq_state_t enum (the opcode enum is already there).
- Sub-module bids_cmd_fifo: parameterised DATAWIDTH+4-bit synchronous FIFO. Ports: push, pop, flush, full, empty, dout, registered output.
- The FSM and counters live in bids_ctrl_sequencer.

## Test plan
- Reset, then push LOADX 100, LOCK 0x5A → C_op=LOADX/C_data=100 exactly two cycles after accept, LOCK two cycles later. err_code=0, busy falls after the final ISSUE.
- Push 5 commands with no pops possible → cmd_ready low after 4 accepts (FIFODEPTH=4), 5th held until a pop.
- START_OP len=3 with eng_ready=1 → C_start high exactly 3 cycles. Then eng_roundOver with maxBid=42 → last_max_bid=42, round_count=1.
- START_OP with eng_ready held 0 → HALT after 255 cycles with err_code=8, FIFO flushed, cmd_ready=0. clr_err → IDLE, cmd_ready=1.
- LOADY issued while engine returns eng_err=3 → err_code=3, halted=1, queued commands discarded and never driven.
- Reset asserted during START with len=10 → C_start=0 and round_count=0 on the next edge.
